// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, issues in-order imem requests,
// tracks them in a reservation FIFO and hands {pc, inst} to decode.
module fetch_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            exe_valid,
    input  logic [1:0]      pc_sel,
    input  logic [XLEN-1:0] br_target,
    input  logic [XLEN-1:0] jalr_target,
    input  logic [XLEN-1:0] evec,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_inst,
    input  logic            if_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW-1:0]   fill_q, fill_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   unfilled_q, unfilled_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0]  entry_pc_q   [DEPTH];
    logic [31:0]      entry_inst_q [DEPTH];
    logic [DEPTH-1:0] entry_filled_q;

    logic redirect, req_fire, resp_drop, resp_fill, resp_fire, pop;
    logic alloc_en, fill_en;

    // Request valid is a pure function of registered state, never of ready/redirect.
    assign redirect       = exe_valid && (pc_sel != 2'd0);
    assign imem_req_valid = (state_q == RUN) && (count_q < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign resp_drop      = imem_resp_valid && (drop_q != '0);
    assign resp_fill      = imem_resp_valid && (drop_q == '0) && (unfilled_q != '0);
    assign resp_fire      = resp_drop || resp_fill;
    assign if_valid       = (count_q != '0) && entry_filled_q[head_q] && !redirect;
    assign if_pc          = entry_pc_q[head_q];
    assign if_inst        = entry_inst_q[head_q];
    assign pop            = if_valid && if_ready;
    assign alloc_en       = req_fire && !redirect;
    assign fill_en        = resp_fill && !redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        count_d    = count_q;
        unfilled_d = unfilled_q;
        drop_d     = drop_q;

        if (redirect) begin
            case (pc_sel)
                2'd1:    fetch_pc_d = br_target;
                2'd2:    fetch_pc_d = jalr_target;
                default: fetch_pc_d = evec;
            endcase
            // Everything still in flight (including this cycle's request) becomes stale.
            count_d    = '0;
            unfilled_d = '0;
            head_d     = tail_q;
            fill_d     = tail_q;
            drop_d     = drop_q + unfilled_q + CW'(req_fire) - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            tail_d     = tail_q + PW'(req_fire);
            head_d     = head_q + PW'(pop);
            fill_d     = fill_q + PW'(resp_fill);
            count_d    = count_q + CW'(req_fire) - CW'(pop);
            unfilled_d = unfilled_q + CW'(req_fire) - CW'(resp_fill);
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
        end

        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (redirect && (drop_d != '0)) state_d = DRAIN;
            DRAIN:   if (drop_d == '0) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
            drop_q     <= drop_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entry_pc_q[gi]     <= '0;
                    entry_inst_q[gi]   <= '0;
                    entry_filled_q[gi] <= 1'b0;
                end else if (alloc_en && (tail_q == PW'(gi))) begin
                    entry_pc_q[gi]     <= fetch_pc_q;
                    entry_filled_q[gi] <= 1'b0;
                end else if (fill_en && (fill_q == PW'(gi))) begin
                    entry_inst_q[gi]   <= imem_resp_data;
                    entry_filled_q[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // A response with nothing waiting for it and nothing to drop is a memory-side bug.
    a_resp_expected: assert property (@(posedge clk) disable iff (reset)
        !(imem_resp_valid && (drop_q == '0) && (unfilled_q == '0)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: in-order memory model with optional response hold.
module tb_fetch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exe_valid = 1'b0;
    logic [1:0]  pc_sel = 2'd0;
    logic [31:0] br_target = '0, jalr_target = '0, evec = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        if_valid;
    logic [31:0] if_pc, if_inst;
    logic        if_ready = 1'b1;

    fetch_ctrl dut (
        .clk(clk), .reset(reset), .exe_valid(exe_valid), .pc_sel(pc_sel),
        .br_target(br_target), .jalr_target(jalr_target), .evec(evec),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_pc(if_pc),
        .if_inst(if_inst), .if_ready(if_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [31:0] pend[$];
    bit mem_hold = 0, mem_one = 0;
    int fire_cnt = 0, pop_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // One clock: sample handshakes just before the edge, then update the memory model.
    task automatic cyc();
        bit f, p;
        logic [31:0] a;
        #1;
        f = imem_req_valid && imem_req_ready;
        a = imem_req_addr;
        p = if_valid && if_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            pend.delete();
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end else begin
            if (f) begin
                pend.push_back(a);
                fire_cnt++;
            end
            if (p) pop_cnt++;
            if (pend.size() > 0 && (!mem_hold || mem_one)) begin
                imem_resp_data  = ~pend.pop_front();
                imem_resp_valid = 1'b1;
                mem_one = 0;
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    endtask

    task automatic do_reset(input bit ck);
        reset = 1'b1;
        exe_valid = 1'b0; pc_sel = 2'd0;
        br_target = '0; jalr_target = '0; evec = '0;
        imem_req_ready = 1'b1; if_ready = 1'b1;
        mem_hold = 0; mem_one = 0;
        fire_cnt = 0; pop_cnt = 0;
        cyc();
        cyc();
        if (ck) begin
            chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
            chk("rst_if_valid", 32'(if_valid), 32'd0);
            chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
            chk("rst_if_pc", if_pc, 32'h0);
            chk("rst_if_inst", if_inst, 32'h0);
        end
        reset = 1'b0;
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (imem_req_valid) begin
                ok = 1;
                break;
            end
            cyc();
        end
    endtask

    initial begin
        bit ok;
        int pops_before;

        // Streaming fetch with 1-cycle memory
        do_reset(1);
        chk("t1_boot_no_req", 32'(imem_req_valid), 32'd0);
        cyc();
        chk("t1_first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_first_req_addr", imem_req_addr, 32'h8000_0000);
        cyc();
        chk("t1_second_addr", imem_req_addr, 32'h8000_0004);
        chk("t1_no_ifv_yet", 32'(if_valid), 32'd0);
        cyc();
        chk("t1_ifv", 32'(if_valid), 32'd1);
        chk("t1_if_pc0", if_pc, 32'h8000_0000);
        chk("t1_if_inst0", if_inst, ~32'h8000_0000);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk($sformatf("t1_ifv%0d", i), 32'(if_valid), 32'd1);
            chk($sformatf("t1_if_pc%0d", i), if_pc, 32'h8000_0000 + 32'(4 * i));
            chk($sformatf("t1_if_inst%0d", i), if_inst, ~(32'h8000_0000 + 32'(4 * i)));
        end

        // Decode stalled: FIFO fills to DEPTH then requests stop
        do_reset(0);
        if_ready = 1'b0;
        repeat (12) cyc();
        chk("t2_fires", 32'(fire_cnt), 32'd4);
        chk("t2_req_stopped", 32'(imem_req_valid), 32'd0);
        if_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_ifv%0d", i), 32'(if_valid), 32'd1);
            chk($sformatf("t2_pop_pc%0d", i), if_pc, 32'h8000_0000 + 32'(4 * i));
            cyc();
            if (i == 0) begin
                chk("t2_resume_valid", 32'(imem_req_valid), 32'd1);
                chk("t2_resume_addr", imem_req_addr, 32'h8000_0010);
            end
        end

        // Branch redirect with 2 outstanding
        do_reset(0);
        mem_hold = 1;
        cyc(); cyc(); cyc();
        imem_req_ready = 1'b0;
        chk("t3_fires", 32'(fire_cnt), 32'd2);
        exe_valid = 1'b1; pc_sel = 2'd1; br_target = 32'h8000_0400;
        cyc();
        exe_valid = 1'b0; pc_sel = 2'd0;
        chk("t3_drain_req0", 32'(imem_req_valid), 32'd0);
        imem_req_ready = 1'b1;
        mem_hold = 0;
        cyc();
        chk("t3_drain_req1", 32'(imem_req_valid), 32'd0);
        cyc();
        chk("t3_drain_req2", 32'(imem_req_valid), 32'd0);
        chk("t3_drain_ifv", 32'(if_valid), 32'd0);
        cyc();
        chk("t3_run_req", 32'(imem_req_valid), 32'd1);
        chk("t3_target_addr", imem_req_addr, 32'h8000_0400);
        cyc();
        chk("t3_ifv_wait", 32'(if_valid), 32'd0);
        cyc();
        chk("t3_ifv", 32'(if_valid), 32'd1);
        chk("t3_if_pc", if_pc, 32'h8000_0400);
        chk("t3_if_inst", if_inst, ~32'h8000_0400);

        // Redirect with same-cycle response and request, one other outstanding
        do_reset(0);
        mem_hold = 1;
        cyc(); cyc();
        mem_one = 1;
        cyc();
        exe_valid = 1'b1; pc_sel = 2'd2; jalr_target = 32'h8000_2000;
        cyc();
        exe_valid = 1'b0; pc_sel = 2'd0;
        chk("t4_fires", 32'(fire_cnt), 32'd3);
        chk("t4_drain_req0", 32'(imem_req_valid), 32'd0);
        mem_hold = 0;
        cyc();
        chk("t4_drain_req1", 32'(imem_req_valid), 32'd0);
        cyc();
        chk("t4_drain_req2", 32'(imem_req_valid), 32'd0);
        chk("t4_drain_ifv", 32'(if_valid), 32'd0);
        cyc();
        chk("t4_run_req", 32'(imem_req_valid), 32'd1);
        chk("t4_target_addr", imem_req_addr, 32'h8000_2000);

        // Exception kills a deliverable head
        do_reset(0);
        if_ready = 1'b0;
        cyc(); cyc(); cyc();
        chk("t5_head_ready", 32'(if_valid), 32'd1);
        if_ready = 1'b1;
        exe_valid = 1'b1; pc_sel = 2'd3; evec = 32'h0000_0100;
        #1;
        chk("t5_killed", 32'(if_valid), 32'd0);
        pops_before = pop_cnt;
        cyc();
        exe_valid = 1'b0; pc_sel = 2'd0;
        chk("t5_no_pop", 32'(pop_cnt), 32'(pops_before));
        wait_req(10, ok);
        chk("t5_req_seen", 32'(ok), 32'd1);
        chk("t5_evec_addr", imem_req_addr, 32'h0000_0100);
        cyc(); cyc();
        chk("t5_ifv", 32'(if_valid), 32'd1);
        chk("t5_if_pc", if_pc, 32'h0000_0100);

        // PC wraps at the top of the address space
        do_reset(0);
        imem_req_ready = 1'b0;
        cyc();
        exe_valid = 1'b1; pc_sel = 2'd1; br_target = 32'hFFFF_FFFC;
        cyc();
        exe_valid = 1'b0; pc_sel = 2'd0;
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        cyc();
        imem_req_ready = 1'b0;
        chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
        cyc();
        chk("t6_ifv", 32'(if_valid), 32'd1);
        chk("t6_if_pc", if_pc, 32'hFFFF_FFFC);

        // Reset in the middle of a drain
        do_reset(0);
        mem_hold = 1;
        cyc(); cyc(); cyc();
        imem_req_ready = 1'b0;
        exe_valid = 1'b1; pc_sel = 2'd1; br_target = 32'h8000_0400;
        cyc();
        exe_valid = 1'b0; pc_sel = 2'd0;
        chk("t7_in_drain", 32'(imem_req_valid), 32'd0);
        reset = 1'b1;
        #1;
        chk("t7_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t7_rst_if_valid", 32'(if_valid), 32'd0);
        chk("t7_rst_addr", imem_req_addr, 32'h8000_0000);
        chk("t7_rst_if_pc", if_pc, 32'h0);
        cyc();
        reset = 1'b0;
        mem_hold = 0;
        imem_req_ready = 1'b1;
        cyc();
        chk("t7_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t7_req_addr", imem_req_addr, 32'h8000_0000);
        cyc(); cyc();
        chk("t7_ifv", 32'(if_valid), 32'd1);
        chk("t7_if_pc", if_pc, 32'h8000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer between the branch unit's PC-select output and the instruction memory port.
- Owns the fetch PC and issues in-order imem requests.
- Tracks in-flight requests in a reservation FIFO and delivers {pc, inst} to decode under valid/ready.
- On a redirect (branch, jump, JALR or exception), flushes the FIFO and discards stale responses still in flight.

Parameters:
- XLEN, 32, address/PC width.
- RESET_PC, 32'h8000_0000, first fetch address after reset.
- DEPTH, 4, reservation FIFO entries; also the maximum number of outstanding requests (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- exe_valid  in  1  pc_sel/targets below are valid this cycle.
- pc_sel  in  2  0=PC_4, 1=PC_BRJMP, 2=PC_JALR, 3=PC_EXC.
- br_target  in  XLEN  branch/JAL target.
- jalr_target  in  XLEN  JALR target.
- evec  in  XLEN  exception vector.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  request address (= fetch_pc).
- imem_resp_valid  in  1  in-order response strobe (no backpressure).
- imem_resp_data  in  32  instruction word.
- if_valid  out  1  head entry filled and deliverable.
- if_pc  out  XLEN  PC of head entry.
- if_inst  out  32  instruction of head entry.
- if_ready  in  1  decode accepts head.

Behaviour:
- Clocking/reset: one clock, clk. reset is asynchronous, active-high. On reset: state=BOOT, fetch_pc=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, if_valid=0, imem_req_addr=RESET_PC, if_pc=0, if_inst=0.
- FSM states: BOOT, RUN, DRAIN.
  - BOOT→RUN unconditionally after one cycle; no request issued in BOOT.
  - RUN→DRAIN when a redirect occurs and drop_cnt_next>0.
  - DRAIN→RUN when drop_cnt reaches 0, evaluated on the cycle the last stale response arrives.
  - Reset mid-operation returns to BOOT in every state; stale responses after reset are the environment's responsibility.
- Redirect: exe_valid && pc_sel!=0.
  - fetch_pc_next = evec (3), jalr_target (2) or br_target (1).
  - Redirect takes priority over the +4 increment.
- Request issue:
  - imem_req_valid = (state==RUN) && (fifo_count < DEPTH). fifo_count includes allocated-but-unfilled entries.
  - req_fire = valid && ready. On req_fire, allocate a FIFO entry {pc=fetch_pc, filled=0} and set fetch_pc += 4 (mod 2^XLEN, wraps silently), unless a redirect occurs that cycle.
  - imem_req_valid must not depend combinationally on imem_req_ready, exe_valid or pc_sel.
- Response:
  - With drop_cnt>0, each imem_resp_valid decrements drop_cnt and the data is discarded.
  - Otherwise it fills the oldest unfilled entry (inst=data, filled=1).
  - A response arriving with no unfilled entry and drop_cnt==0 is a protocol error: assertion, data ignored.
- Delivery:
  - if_valid = head entry filled and no redirect this cycle. Redirect kills the head combinationally, matching dec_kill.
  - Pop on if_valid && if_ready.
- Flush on redirect:
  - FIFO emptied.
  - drop_cnt_next = drop_cnt + unfilled_entries + req_fire − resp_fire. A same-cycle request counts as stale; a same-cycle response is counted as received.
  - A same-cycle pop is discarded.
- Redirect in DRAIN: fetch_pc updated; drop_cnt follows the same formula (req_fire=0).
- FIFO full, all entries filled, if_ready=0: no requests; state holds.
- DEPTH outstanding: no request until a pop frees an entry. A pop and a request in the same cycle is allowed.

Test Plan:
- Reset, ready=1, 1-cycle memory latency, if_ready=1 → requests 8000_0000, _0004, _0008…; if_pc follows the same sequence one cycle after each response; first request issued in the second cycle after reset release.
- if_ready=0, memory always responds → exactly 4 requests, then imem_req_valid=0; raise if_ready → 4 pops in order, fetching resumes at 8000_0010.
- 2 requests outstanding, redirect pc_sel=1, br_target=8000_0400 → FSM enters DRAIN; the next 2 responses are dropped; next request addr=8000_0400; if_valid stays 0 until that response.
- Redirect in the same cycle as a response and a req_fire with 1 other outstanding → drop_cnt=2; exactly 2 later responses discarded.
- pc_sel=3 with evec=0000_0100 in the same cycle as if_valid=1, if_ready=1 → if_valid forced 0, no pop; next request addr 0000_0100.
- fetch_pc=FFFF_FFFC, one request fires → next addr 0000_0000.
- Assert reset while in DRAIN → outputs return to reset values immediately; first request addr is RESET_PC.
